// File: rtl/map_ram_arbiter.sv
// Arbiter that owns the single-port map RAM and shares it between the renderer (port 0),
// pacman collision (port 1) and ghost movement (port 2); cell writes are atomic read-modify-write.
module map_ram_arbiter #(
    parameter int ROWS          = 30,
    parameter int COLS          = 40,
    parameter int RD_LAT        = 1,
    parameter int MAX_P0_STREAK = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [2:0]   req,
    input  logic [5:0]   op,
    input  logic [14:0]  row,
    input  logic [17:0]  col,
    input  logic [11:0]  wdata,
    output logic [2:0]   ack,
    output logic         err,
    output logic [159:0] rd_row,
    output logic [3:0]   rd_cell,
    output logic         busy,
    output logic [4:0]   ram_addr,
    output logic [159:0] ram_wdata,
    output logic         ram_wren,
    input  logic [159:0] ram_q,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int             SW         = $clog2(MAX_P0_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_P0_STREAK);
    localparam logic [4:0]     ROWS_L     = 5'(ROWS);
    localparam logic [5:0]     COLS_L     = 6'(COLS);
    localparam logic [1:0]     WAIT_INIT  = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_t         r_state;
    logic [1:0]     r_port;
    logic [1:0]     r_op;
    logic [4:0]     r_row;
    logic [5:0]     r_col;
    logic [3:0]     r_wdata;
    logic [SW-1:0]  r_streak;
    logic           r_last2;
    logic [1:0]     r_wait;
    logic [2:0]     r_ack;
    logic           r_err;
    logic [159:0]   r_rd_row;
    logic [3:0]     r_rd_cell;
    logic [4:0]     r_ram_addr;
    logic [159:0]   r_ram_wdata;
    logic           r_ram_wren;

    logic           w_p12;
    logic [1:0]     w_gnt_port;
    logic [1:0]     w_sel_op;
    logic [4:0]     w_sel_row;
    logic [5:0]     w_sel_col;
    logic [3:0]     w_sel_wdata;
    logic           w_oor;
    logic           w_col_ok;
    logic [7:0]     w_lsb;
    logic [3:0]     w_old;
    logic [3:0]     w_new_nib;
    logic           w_do_wr;
    logic [159:0]   w_mask;
    logic [159:0]   w_new_row;

    // Port 0 wins unless its streak is exhausted; ports 1 and 2 strictly alternate.
    always_comb begin
        w_p12      = req[1] | req[2];
        w_gnt_port = 2'd0;
        if (req[0] && !((r_streak == STREAK_MAX) && w_p12))
            w_gnt_port = 2'd0;
        else if (req[1] && req[2])
            w_gnt_port = r_last2 ? 2'd1 : 2'd2;
        else if (req[1])
            w_gnt_port = 2'd1;
        else if (req[2])
            w_gnt_port = 2'd2;

        case (w_gnt_port)
            2'd1: begin
                w_sel_op    = op[3:2];
                w_sel_row   = row[9:5];
                w_sel_col   = col[11:6];
                w_sel_wdata = wdata[7:4];
            end
            2'd2: begin
                w_sel_op    = op[5:4];
                w_sel_row   = row[14:10];
                w_sel_col   = col[17:12];
                w_sel_wdata = wdata[11:8];
            end
            default: begin
                w_sel_op    = 2'b00;
                w_sel_row   = row[4:0];
                w_sel_col   = col[5:0];
                w_sel_wdata = wdata[3:0];
            end
        endcase
        if (w_sel_op == 2'b11)
            w_sel_op = 2'b00;

        w_oor = (w_sel_row >= ROWS_L) || ((w_gnt_port != 2'd0) && (w_sel_col >= COLS_L));
    end

    // Column 0 is the most significant nibble of the row word.
    always_comb begin
        w_col_ok  = (r_col < COLS_L);
        w_lsb     = 8'd156 - {r_col, 2'b00};
        w_old     = w_col_ok ? ram_q[w_lsb +: 4] : 4'h0;
        w_do_wr   = 1'b0;
        w_new_nib = r_wdata;
        case (r_op)
            2'b01: w_do_wr = w_col_ok;
            2'b10: begin
                case (w_old)
                    4'h2, 4'h3: begin
                        w_do_wr   = 1'b1;
                        w_new_nib = 4'h0;
                    end
                    4'h6, 4'h7: begin
                        w_do_wr   = 1'b1;
                        w_new_nib = 4'h5;
                    end
                    default: w_do_wr = 1'b0;
                endcase
            end
            default: w_do_wr = 1'b0;
        endcase
        w_mask    = {156'd0, 4'hF} << w_lsb;
        w_new_row = (ram_q & ~w_mask) | ({156'd0, w_new_nib} << w_lsb);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_port      <= 2'd0;
            r_op        <= 2'd0;
            r_row       <= 5'd0;
            r_col       <= 6'd0;
            r_wdata     <= 4'd0;
            r_streak    <= '0;
            r_last2     <= 1'b1;
            r_wait      <= 2'd0;
            r_ack       <= 3'd0;
            r_err       <= 1'b0;
            r_rd_row    <= 160'd0;
            r_rd_cell   <= 4'd0;
            r_ram_addr  <= 5'd0;
            r_ram_wdata <= 160'd0;
            r_ram_wren  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_port  <= w_gnt_port;
                        r_op    <= w_sel_op;
                        r_row   <= w_sel_row;
                        r_col   <= w_sel_col;
                        r_wdata <= w_sel_wdata;
                        if (w_gnt_port == 2'd0) begin
                            if (w_p12 && (r_streak != STREAK_MAX))
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_streak <= '0;
                            r_last2  <= (w_gnt_port == 2'd2);
                        end
                        if (w_oor) begin
                            r_state   <= S_DONE;
                            r_ack     <= 3'b001 << w_gnt_port;
                            r_err     <= 1'b1;
                            r_rd_row  <= 160'd0;
                            r_rd_cell <= 4'd0;
                        end else begin
                            r_state    <= S_RD;
                            r_ram_addr <= w_sel_row;
                        end
                    end
                end
                S_RD: begin
                    if (RD_LAT > 1) begin
                        r_wait  <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_WAIT: begin
                    if (r_wait == 2'd0)
                        r_state <= S_CAP;
                    else
                        r_wait <= r_wait - 2'd1;
                end
                S_CAP: begin
                    r_rd_row  <= ram_q;
                    r_rd_cell <= w_old;
                    r_err     <= 1'b0;
                    if (w_do_wr) begin
                        r_ram_wren  <= 1'b1;
                        r_ram_wdata <= w_new_row;
                        r_state     <= S_WR;
                    end else begin
                        r_ack   <= 3'b001 << r_port;
                        r_state <= S_DONE;
                    end
                end
                S_WR: begin
                    r_ram_wren <= 1'b0;
                    r_ack      <= 3'b001 << r_port;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_ack   <= 3'd0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign rd_row    = r_rd_row;
    assign rd_cell   = r_rd_cell;
    assign busy      = (r_state != S_IDLE);
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_wren  = r_ram_wren;
    assign dbg_state = r_state;

endmodule
